issue_queue_free_list: RTL and testbench

//  Owns free issue-queue (IQ) entries; the return path of the wakeup/select release protocol.
//  - Consumes releaseEntry/releasePtr from the wakeup pipeline register.
//  - Hands free IQ indices to dispatch as writePtr.
//  - Circular FIFO of entry indices; up to ISSUE_WIDTH pushes and DISPATCH_WIDTH pops per cycle.

---
 rtl/issue_queue_free_list_pkg.sv | 17 +
 rtl/issue_queue_free_list_if.sv | 31 +++
 rtl/issue_queue_free_list_lane_offset.sv | 23 ++
 rtl/issue_queue_free_list.sv | 138 +++++++++++++
 tb/tb_issue_queue_free_list.sv | 230 +++++++++++++++++++++++
 5 files changed

// File: rtl/issue_queue_free_list_pkg.sv
// Shared scheduler types for the issue-queue free list.
// Index and count widths derive from the entry count.
package issue_queue_free_list_pkg;

  localparam int ISSUE_QUEUE_ENTRY_NUM = 16;
  localparam int DISPATCH_WIDTH = 2;
  localparam int ISSUE_WIDTH = 4;
  localparam int ISSUE_QUEUE_ENTRY_NUM_BIT_WIDTH =
    $clog2(ISSUE_QUEUE_ENTRY_NUM);

  typedef logic [ISSUE_QUEUE_ENTRY_NUM_BIT_WIDTH-1:0]
    IssueQueueIndexPath;

  typedef logic [ISSUE_QUEUE_ENTRY_NUM_BIT_WIDTH:0]
    IssueQueueCountPath;

endpackage

// File: rtl/issue_queue_free_list_if.sv
// Dispatch allocation and wakeup release bundle
// between the scheduler and the IQ free list.
interface issue_queue_free_list_if;
  import issue_queue_free_list_pkg::*;

  logic [DISPATCH_WIDTH-1:0] allocReq;
  IssueQueueIndexPath [DISPATCH_WIDTH-1:0] allocPtr;
  logic allocatable;
  logic [ISSUE_WIDTH-1:0] releaseEntry;
  IssueQueueIndexPath [ISSUE_WIDTH-1:0] releasePtr;
  IssueQueueCountPath freeCount;

  modport master (
    output allocReq,
    output releaseEntry,
    output releasePtr,
    input  allocPtr,
    input  allocatable,
    input  freeCount
  );

  modport slave (
    input  allocReq,
    input  releaseEntry,
    input  releasePtr,
    output allocPtr,
    output allocatable,
    output freeCount
  );

endinterface

// File: rtl/issue_queue_free_list_lane_offset.sv
// Prefix popcount: per-lane count of set lower lanes,
// plus the total number of set lanes.
module free_list_lane_offset #(
  parameter int WIDTH = 4,
  parameter int OFS_BITS = $clog2(WIDTH + 1)
) (
  input  logic [WIDTH-1:0] req,
  output logic [WIDTH-1:0][OFS_BITS-1:0] offset,
  output logic [OFS_BITS-1:0] total
);

  logic [OFS_BITS-1:0] acc;

  always_comb begin
    acc = '0;
    for (int i = 0; i < WIDTH; i++) begin
      offset[i] = acc;
      acc = acc + {{(OFS_BITS-1){1'b0}}, req[i]};
    end
    total = acc;
  end

endmodule

// File: rtl/issue_queue_free_list.sv
// Circular free list of IQ entry indices: dispatch pops
// from head, wakeup/select releases push at tail.
module issue_queue_free_list
  import issue_queue_free_list_pkg::*;
(
  input logic clk,
  input logic rst,
  input logic flush,
  issue_queue_free_list_if.slave iq
);

  localparam int N = ISSUE_QUEUE_ENTRY_NUM;
  localparam int AB = $clog2(DISPATCH_WIDTH + 1);
  localparam int RB = $clog2(ISSUE_WIDTH + 1);

  IssueQueueIndexPath slot [N];
  IssueQueueIndexPath head;
  IssueQueueIndexPath tail;
  IssueQueueCountPath count;
  IssueQueueCountPath countNext;

  logic [DISPATCH_WIDTH-1:0][AB-1:0] allocOfs;
  logic [AB-1:0] allocTotal;
  logic [ISSUE_WIDTH-1:0][RB-1:0] relOfs;
  logic [RB-1:0] relTotal;

  free_list_lane_offset #(
    .WIDTH(DISPATCH_WIDTH)
  ) allocLanes (
    .req(iq.allocReq),
    .offset(allocOfs),
    .total(allocTotal)
  );

  free_list_lane_offset #(
    .WIDTH(ISSUE_WIDTH)
  ) releaseLanes (
    .req(iq.releaseEntry),
    .offset(relOfs),
    .total(relTotal)
  );

  // Lane i skips past entries taken by lower lanes only.
  always_comb begin
    for (int i = 0; i < DISPATCH_WIDTH; i++) begin
      iq.allocPtr[i] =
        slot[head + IssueQueueIndexPath'(allocOfs[i])];
    end
  end

  always_comb begin
    countNext = count
      - IssueQueueCountPath'(allocTotal)
      + IssueQueueCountPath'(relTotal);
  end

  assign iq.allocatable =
    (count >= IssueQueueCountPath'(DISPATCH_WIDTH));
  assign iq.freeCount = count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < N; k++) begin
        slot[k] <= IssueQueueIndexPath'(k);
      end
      head <= '0;
      tail <= '0;
      count <= IssueQueueCountPath'(N);
    end else if (flush) begin
      for (int k = 0; k < N; k++) begin
        slot[k] <= IssueQueueIndexPath'(k);
      end
      head <= '0;
      tail <= '0;
      count <= IssueQueueCountPath'(N);
    end else begin
      for (int j = 0; j < ISSUE_WIDTH; j++) begin
        if (iq.releaseEntry[j]) begin
          slot[tail + IssueQueueIndexPath'(relOfs[j])]
            <= iq.releasePtr[j];
        end
      end
      head <= head + IssueQueueIndexPath'(allocTotal);
      tail <= tail + IssueQueueIndexPath'(relTotal);
      count <= countNext;
    end
  end

  // Shadow ownership map, only feeds the protocol checks.
  logic [N-1:0] freeMap;
  logic [N-1:0] freeMapNext;
  int countNextWide;

  always_comb begin
    countNextWide = int'(count)
      - int'(allocTotal) + int'(relTotal);
  end

  always_comb begin
    freeMapNext = freeMap;
    for (int i = 0; i < DISPATCH_WIDTH; i++) begin
      if (iq.allocReq[i]) begin
        freeMapNext[iq.allocPtr[i]] = 1'b0;
      end
    end
    for (int j = 0; j < ISSUE_WIDTH; j++) begin
      if (iq.releaseEntry[j]) begin
        freeMapNext[iq.releasePtr[j]] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      freeMap <= '1;
    end else if (flush) begin
      freeMap <= '1;
    end else begin
      assert (iq.allocReq == '0 || iq.allocatable)
        else $error("alloc while not allocatable");
      assert (countNextWide <= N)
        else $error("free list over-release");
      for (int j = 0; j < ISSUE_WIDTH; j++) begin
        if (iq.releaseEntry[j]) begin
          assert (!freeMap[iq.releasePtr[j]])
            else $error("release of free entry");
          for (int k = j + 1; k < ISSUE_WIDTH; k++) begin
            assert (!(iq.releaseEntry[k] &&
                      iq.releasePtr[k] == iq.releasePtr[j]))
              else $error("duplicate release");
          end
        end
      end
      freeMap <= freeMapNext;
    end
  end

endmodule

// File: tb/tb_issue_queue_free_list.sv
// Directed vector table, random FIFO scoreboard, and
// async reset sequence for the IQ free list.
module tb_issue_queue_free_list;
  import issue_queue_free_list_pkg::*;

  logic clk = 1'b0;
  logic rst;
  logic flush;

  issue_queue_free_list_if iq();

  issue_queue_free_list dut (
    .clk(clk),
    .rst(rst),
    .flush(flush),
    .iq(iq)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic fl;
    logic [1:0] ar;
    logic [3:0] re;
    IssueQueueIndexPath [3:0] rp;
    IssueQueueIndexPath [1:0] ePtr;
    logic eAl;
    IssueQueueCountPath eCnt;
  } vec_t;

  vec_t tbl [$];
  int nChk = 0;
  int nErr = 0;

  function automatic vec_t mk(
    logic fl, logic [1:0] ar, logic [3:0] re,
    int r0, int r1, int r2, int r3,
    int e0, int e1, logic al, int cnt
  );
    vec_t t;
    t.fl = fl;
    t.ar = ar;
    t.re = re;
    t.rp[0] = IssueQueueIndexPath'(r0);
    t.rp[1] = IssueQueueIndexPath'(r1);
    t.rp[2] = IssueQueueIndexPath'(r2);
    t.rp[3] = IssueQueueIndexPath'(r3);
    t.ePtr[0] = IssueQueueIndexPath'(e0);
    t.ePtr[1] = IssueQueueIndexPath'(e1);
    t.eAl = al;
    t.eCnt = IssueQueueCountPath'(cnt);
    return t;
  endfunction

  task automatic chk(string nm, int act, int exp);
    nChk++;
    if (act != exp) begin
      nErr++;
      $display("FAIL %s: got %0d expected %0d",
               nm, act, exp);
    end
  endtask

  task automatic drive(
    logic fl, logic [1:0] ar, logic [3:0] re,
    IssueQueueIndexPath [3:0] rp
  );
    flush = fl;
    iq.allocReq = ar;
    iq.releaseEntry = re;
    iq.releasePtr = rp;
  endtask

  task automatic chkOut(
    string nm, int p0, int p1, int al, int cnt
  );
    chk({nm, " ptr0"}, iq.allocPtr[0], p0);
    chk({nm, " ptr1"}, iq.allocPtr[1], p1);
    chk({nm, " allocatable"}, iq.allocatable, al);
    chk({nm, " freeCount"}, iq.freeCount, cnt);
  endtask

  task automatic pulseReset();
    @(negedge clk);
    rst = 1'b1;
    drive(1'b0, 2'b00, 4'b0000, '0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  IssueQueueIndexPath q [$];
  bit held [16];
  IssueQueueIndexPath hl [$];
  IssueQueueIndexPath [3:0] rp;
  logic [1:0] ar;
  logic [3:0] re;
  int a;

  initial begin
    rst = 1'b1;
    drive(1'b0, 2'b11, 4'b0000, '0);
    #12;
    chkOut("reset", 0, 1, 1, 16);
    @(negedge clk);
    rst = 1'b0;
    drive(1'b0, 2'b00, 4'b0000, '0);

    for (int c = 0; c < 8; c++) begin
      tbl.push_back(mk(0, 2'b11, 4'b0000, 0, 0, 0, 0,
                       2 * c, 2 * c + 1, 1, 16 - 2 * c));
    end
    tbl.push_back(mk(0, 2'b00, 4'b0000, 0, 0, 0, 0,
                     0, 0, 0, 0));
    tbl.push_back(mk(0, 2'b00, 4'b0101, 5, 0, 9, 0,
                     0, 0, 0, 0));
    tbl.push_back(mk(0, 2'b10, 4'b0000, 0, 0, 0, 0,
                     5, 5, 1, 2));
    tbl.push_back(mk(0, 2'b00, 4'b0010, 0, 3, 0, 0,
                     9, 9, 0, 1));
    tbl.push_back(mk(0, 2'b11, 4'b1111, 7, 0, 12, 5,
                     9, 3, 1, 2));
    tbl.push_back(mk(0, 2'b11, 4'b0000, 0, 0, 0, 0,
                     7, 0, 1, 4));
    tbl.push_back(mk(0, 2'b11, 4'b0000, 0, 0, 0, 0,
                     12, 5, 1, 2));
    tbl.push_back(mk(0, 2'b00, 4'b0111, 1, 2, 4, 0,
                     7, 7, 0, 0));
    tbl.push_back(mk(1, 2'b11, 4'b1000, 0, 0, 0, 6,
                     1, 2, 1, 3));
    tbl.push_back(mk(0, 2'b11, 4'b0000, 0, 0, 0, 0,
                     0, 1, 1, 16));
    tbl.push_back(mk(0, 2'b00, 4'b0000, 0, 0, 0, 0,
                     2, 2, 1, 14));

    foreach (tbl[v]) begin
      @(negedge clk);
      drive(tbl[v].fl, tbl[v].ar, tbl[v].re, tbl[v].rp);
      #1;
      chkOut($sformatf("vec%0d", v),
             tbl[v].ePtr[0], tbl[v].ePtr[1],
             tbl[v].eAl, tbl[v].eCnt);
    end

    // Random traffic against an in-order FIFO model.
    pulseReset();
    q.delete();
    for (int k = 0; k < 16; k++) begin
      q.push_back(IssueQueueIndexPath'(k));
      held[k] = 1'b0;
    end
    for (int cyc = 0; cyc < 40; cyc++) begin
      @(negedge clk);
      ar = (q.size() >= 2) ?
        2'($urandom_range(0, 3)) : 2'b00;
      hl.delete();
      for (int k = 0; k < 16; k++) begin
        if (held[k]) hl.push_back(IssueQueueIndexPath'(k));
      end
      re = '0;
      rp = '0;
      for (int j = 0; j < 4; j++) begin
        if (hl.size() > 0 && $urandom_range(0, 2) == 0) begin
          a = $urandom_range(0, hl.size() - 1);
          rp[j] = hl[a];
          hl.delete(a);
          re[j] = 1'b1;
        end
      end
      drive(1'b0, ar, re, rp);
      #1;
      chk($sformatf("rand%0d freeCount", cyc),
          iq.freeCount, q.size());
      chk($sformatf("rand%0d allocatable", cyc),
          iq.allocatable, int'(q.size() >= 2));
      a = 0;
      for (int i = 0; i < 2; i++) begin
        if (ar[i]) begin
          chk($sformatf("rand%0d ptr%0d", cyc, i),
              iq.allocPtr[i], q[a]);
          chk($sformatf("rand%0d ptr%0d held", cyc, i),
              held[iq.allocPtr[i]], 0);
          a++;
        end
      end
      for (int i = 0; i < a; i++) begin
        held[q.pop_front()] = 1'b1;
      end
      for (int j = 0; j < 4; j++) begin
        if (re[j]) begin
          q.push_back(rp[j]);
          held[rp[j]] = 1'b0;
        end
      end
    end
    @(negedge clk);
    drive(1'b0, 2'b00, 4'b0000, '0);
    #1;
    chk("rand final freeCount", iq.freeCount, q.size());

    // Async reset mid-cycle with three free entries.
    pulseReset();
    for (int c = 0; c < 7; c++) begin
      @(negedge clk);
      drive(1'b0, (c < 6) ? 2'b11 : 2'b01, 4'b0000, '0);
    end
    @(negedge clk);
    rp = '0;
    rp[1] = 4'd1;
    drive(1'b0, 2'b11, 4'b0011, rp);
    #1;
    chk("pre-rst freeCount", iq.freeCount, 3);
    #1;
    rst = 1'b1;
    #1;
    chkOut("async rst", 0, 1, 1, 16);
    @(negedge clk);
    rst = 1'b0;
    drive(1'b0, 2'b11, 4'b0000, '0);
    #1;
    chkOut("post rst", 0, 1, 1, 16);
    @(negedge clk);
    #1;
    chkOut("first alloc", 2, 3, 1, 14);

    $display("== %0d vectors applied, %0d miscompares ==",
             nChk, nErr);
    $finish;
  end

endmodule
